// File: rtl/seq_alu_accumulator.sv
// Sequential accumulator ALU: edge-triggered load/go commands, single-cycle ops
// and a WIDTH-cycle shift-add multiply producing a double-width product.
module seq_alu_accumulator #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] operand,
   input  logic [2:0]       op_sel,
   input  logic             load,
   input  logic             go,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] acc_hi,
   output logic [3:0]       flags,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_CMP = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_SHL = 3'b111;

   typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

   state_t               state, state_nx;
   logic                 load_q, go_q;
   logic                 load_rise, go_rise;
   logic [WIDTH-1:0]     b;
   logic [2:0]           op;
   logic [SHW-1:0]       count;
   logic [2*WIDTH-1:0]   prod, prod_nx;
   logic                 mul_last;

   logic [WIDTH-1:0]     res;
   logic                 res_c, res_v;
   logic [WIDTH:0]       sum, diff, shl_ext;
   logic [SHW-1:0]       shamt;

   assign load_rise = load & ~load_q;
   assign go_rise   = go & ~go_q;
   assign busy      = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (!load_rise && go_rise)
               state_nx = (op_sel == OP_MUL) ? MUL : EXEC;
         end
         EXEC:    state_nx = IDLE;
         MUL:     if (mul_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Single-cycle result path; V uses two's-complement sign rules
   always_comb begin
      sum     = {1'b0, acc} + {1'b0, b};
      diff    = {1'b0, acc} - {1'b0, b};
      shamt   = b[SHW-1:0];
      shl_ext = {1'b0, acc} << shamt;
      res     = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      case (op)
         OP_ADD: begin
            res   = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (acc[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != acc[WIDTH-1]);
         end
         OP_SUB: begin
            res   = diff[WIDTH-1:0];
            res_c = diff[WIDTH];
            res_v = (acc[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != acc[WIDTH-1]);
         end
         OP_AND: res = acc & b;
         OP_OR:  res = acc | b;
         OP_XOR: res = acc ^ b;
         OP_CMP: begin
            res[2] = (acc > b);
            res[1] = (acc == b);
            res[0] = (acc < b);
         end
         OP_SHL: begin
            if (int'(shamt) < WIDTH) begin
               res   = shl_ext[WIDTH-1:0];
               res_c = shl_ext[WIDTH];
            end
         end
         default: res = acc;
      endcase
   end

   // One shift-add step per cycle, multiplicand is the untouched acc
   always_comb begin
      prod_nx  = prod + (b[count] ? ({{WIDTH{1'b0}}, acc} << count) : '0);
      mul_last = (count == SHW'(WIDTH - 1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc    <= '0;
         acc_hi <= '0;
         flags  <= 4'b0100;
         done   <= 1'b0;
         load_q <= 1'b0;
         go_q   <= 1'b0;
         b      <= '0;
         op     <= OP_ADD;
         count  <= '0;
         prod   <= '0;
      end else begin
         load_q <= load;
         go_q   <= go;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               if (load_rise) begin
                  acc    <= operand;
                  acc_hi <= '0;
                  flags  <= {operand[WIDTH-1], (operand == '0), 2'b00};
               end else if (go_rise) begin
                  b     <= operand;
                  op    <= op_sel;
                  count <= '0;
                  prod  <= '0;
               end
            end
            EXEC: begin
               acc    <= res;
               acc_hi <= '0;
               flags  <= {res[WIDTH-1], (res == '0), res_v, res_c};
               done   <= 1'b1;
            end
            MUL: begin
               prod  <= prod_nx;
               count <= count + 1'b1;
               if (mul_last) begin
                  acc    <= prod_nx[WIDTH-1:0];
                  acc_hi <= prod_nx[2*WIDTH-1:WIDTH];
                  flags  <= {prod_nx[WIDTH-1], (prod_nx[WIDTH-1:0] == '0), 1'b0,
                             (prod_nx[2*WIDTH-1:WIDTH] != '0)};
                  done   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu_accumulator.sv
// Bench for seq_alu_accumulator: vector table through a done-driven scoreboard,
// plus hand sequences for busy-ignore, held go, load/go collision and mid-MUL reset.
module tb_seq_alu_accumulator;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] operand;
   logic [2:0] op_sel;
   logic       load;
   logic       go;
   logic [7:0] acc;
   logic [7:0] acc_hi;
   logic [3:0] flags;
   logic       busy;
   logic       done;

   seq_alu_accumulator #(.WIDTH(8), .SHW(3)) dut (
      .clock(clock), .reset(reset), .operand(operand), .op_sel(op_sel),
      .load(load), .go(go), .acc(acc), .acc_hi(acc_hi), .flags(flags),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] a;
      logic [2:0] op;
      logic [7:0] b;
      logic [7:0] acc;
      logic [7:0] hi;
      logic [3:0] flags;
   } vec_t;

   typedef struct {
      logic [7:0] acc;
      logic [7:0] hi;
      logic [3:0] flags;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   done_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation
   always @(negedge clock) begin
      if (done === 1'b1) begin
         exp_t e;
         done_seen++;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(1), 32'(0));
         end else begin
            e = sb.pop_front();
            check("sb_acc", 32'(acc), 32'(e.acc));
            check("sb_acc_hi", 32'(acc_hi), 32'(e.hi));
            check("sb_flags", 32'(flags), 32'(e.flags));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      operand = v;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      check("load_acc", 32'(acc), 32'(v));
      check("load_flags", 32'(flags), 32'({v[7], (v == 8'h00), 2'b00}));
   endtask

   // Drive one go rise; optionally pulse go/load mid-operation to prove they are ignored
   task automatic do_op(input logic [2:0] o, input logic [7:0] bv, input exp_t e,
                        input bit disturb);
      int cyc;
      int busy_cnt;
      int exp_lat;
      sb.push_back(e);
      operand  = bv;
      op_sel   = o;
      go       = 1'b1;
      cyc      = 0;
      busy_cnt = 0;
      exp_lat  = (o == 3'b110) ? 9 : 2;
      do begin
         tick();
         cyc++;
         if (cyc == 1) go = 1'b0;
         if (disturb && cyc == 3) begin
            go = 1'b1; load = 1'b1; operand = 8'h55; op_sel = 3'b000;
         end
         if (disturb && cyc == 4) begin
            go = 1'b0; load = 1'b0;
         end
         if (busy === 1'b1) busy_cnt++;
      end while (done !== 1'b1 && cyc < 30);
      if (done !== 1'b1) begin
         check("op_timeout", 32'(cyc), 32'(exp_lat));
         if (sb.size() > 0) void'(sb.pop_back());
      end else begin
         check("op_latency", 32'(cyc), 32'(exp_lat));
         check("op_busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
      end
   endtask

   vec_t vecs[15];

   initial begin
      int   base;
      exp_t e;
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   base;
      exp_t e;
      vecs[0]  = '{8'h7F, 3'd0, 8'h01, 8'h80, 8'h00, 4'b1010};
      vecs[1]  = '{8'h05, 3'd1, 8'h07, 8'hFE, 8'h00, 4'b1001};
      vecs[2]  = '{8'hFF, 3'd0, 8'h01, 8'h00, 8'h00, 4'b0101};
      vecs[3]  = '{8'h80, 3'd1, 8'h01, 8'h7F, 8'h00, 4'b0010};
      vecs[4]  = '{8'hF0, 3'd2, 8'h3C, 8'h30, 8'h00, 4'b0000};
      vecs[5]  = '{8'hF0, 3'd3, 8'h0F, 8'hFF, 8'h00, 4'b1000};
      vecs[6]  = '{8'hAA, 3'd4, 8'hAA, 8'h00, 8'h00, 4'b0100};
      vecs[7]  = '{8'h10, 3'd5, 8'h20, 8'h01, 8'h00, 4'b0000};
      vecs[8]  = '{8'h30, 3'd5, 8'h20, 8'h04, 8'h00, 4'b0000};
      vecs[9]  = '{8'hFF, 3'd6, 8'hFF, 8'h01, 8'hFE, 4'b0001};
      vecs[10] = '{8'h0C, 3'd6, 8'h0B, 8'h84, 8'h00, 4'b1000};
      vecs[11] = '{8'h81, 3'd7, 8'h01, 8'h02, 8'h00, 4'b0001};
      vecs[12] = '{8'h81, 3'd7, 8'h00, 8'h81, 8'h00, 4'b1000};
      vecs[13] = '{8'h03, 3'd7, 8'h07, 8'h80, 8'h00, 4'b1001};
      vecs[14] = '{8'h20, 3'd6, 8'h08, 8'h00, 8'h01, 4'b0101};

      reset = 1'b1; operand = 8'h00; op_sel = 3'd0; load = 1'b0; go = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_acc", 32'(acc), 32'(0));
      check("rst_acc_hi", 32'(acc_hi), 32'(0));
      check("rst_flags", 32'(flags), 32'(4'b0100));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));

      for (int i = 0; i < 15; i++) begin
         do_load(vecs[i].a);
         e = '{vecs[i].acc, vecs[i].hi, vecs[i].flags};
         do_op(vecs[i].op, vecs[i].b, e, 1'b0);
      end

      // SUB then CMP on the result
      do_load(8'h05);
      do_op(3'd1, 8'h07, '{8'hFE, 8'h00, 4'b1001}, 1'b0);
      do_op(3'd5, 8'hFE, '{8'h02, 8'h00, 4'b0000}, 1'b0);

      // MUL with go/load pulsed while busy
      do_load(8'hFF);
      base = done_seen;
      do_op(3'd6, 8'hFF, '{8'h01, 8'hFE, 4'b0001}, 1'b1);
      repeat (4) tick();
      check("busy_ignore_done_count", 32'(done_seen - base), 32'(1));
      check("busy_ignore_acc", 32'(acc), 32'(8'h01));
      check("busy_ignore_busy", 32'(busy), 32'(0));

      // go held high for 20 cycles gives one op
      do_load(8'h01);
      base = done_seen;
      sb.push_back('{8'h02, 8'h00, 4'b0000});
      operand = 8'h01; op_sel = 3'd0; go = 1'b1;
      repeat (20) tick();
      go = 1'b0;
      repeat (3) tick();
      check("held_go_done_count", 32'(done_seen - base), 32'(1));
      check("held_go_acc", 32'(acc), 32'(8'h02));

      // load and go rise together: load wins
      base = done_seen;
      operand = 8'h33; op_sel = 3'd0; load = 1'b1; go = 1'b1;
      tick();
      load = 1'b0; go = 1'b0;
      check("collide_busy", 32'(busy), 32'(0));
      repeat (4) tick();
      check("collide_acc", 32'(acc), 32'(8'h33));
      check("collide_flags", 32'(flags), 32'(4'b0000));
      check("collide_busy_late", 32'(busy), 32'(0));
      check("collide_done_count", 32'(done_seen - base), 32'(0));

      // reset during MUL abandons the op
      do_load(8'hFF);
      base = done_seen;
      operand = 8'hFF; op_sel = 3'd6; go = 1'b1;
      tick();
      go = 1'b0;
      check("mul_busy", 32'(busy), 32'(1));
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_acc", 32'(acc), 32'(0));
      check("midrst_acc_hi", 32'(acc_hi), 32'(0));
      check("midrst_flags", 32'(flags), 32'(4'b0100));
      check("midrst_busy", 32'(busy), 32'(0));
      repeat (10) tick();
      check("midrst_done_count", 32'(done_seen - base), 32'(0));
      check("midrst_busy_late", 32'(busy), 32'(0));
      do_load(8'h81);
      do_op(3'd7, 8'h01, '{8'h02, 8'h00, 4'b0001}, 1'b0);

      repeat (3) tick();
      check("sb_leftover", 32'(sb.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
